// File: rtl/ppcpu_trace_buffer_pkg.sv
// Shared definitions for the pipelined-CPU trace buffer.
//   trc_state_e : capture FSM states, encoded as reported on the State port
//   TRC_W       : width of one trace entry {PC, ID_Inst, WB_Alu}
//   trc_entry_t : packed view of one trace entry with named fields
//   trc_pack    : builds an entry from the three observed CPU signals
package ppcpu_trace_buffer_pkg;

  localparam int unsigned TRC_W = 96;

  typedef enum logic [1:0] {
    TRC_IDLE  = 2'd0,
    TRC_ARMED = 2'd1,
    TRC_POST  = 2'd2,
    TRC_DUMP  = 2'd3
  } trc_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu;
  } trc_entry_t;

  function automatic trc_entry_t trc_pack(input logic [31:0] pc,
                                          input logic [31:0] inst,
                                          input logic [31:0] alu);
    trc_entry_t e;
    e.pc   = pc;
    e.inst = inst;
    e.alu  = alu;
    return e;
  endfunction

endpackage

// File: rtl/ppcpu_trace_buffer_if.sv
// Read-out port of the trace buffer: valid/ready stream of captured entries.
//   RdValid : entry on RdPC/RdInst/RdAlu is valid
//   RdReady : sink accepts the current entry
//   RdPC    : entry PC field
//   RdInst  : entry instruction field
//   RdAlu   : entry ALU-result field
// master = trace buffer (source), slave = consumer (sink).
interface ppcpu_trace_buffer_if;
  logic        RdValid;
  logic        RdReady;
  logic [31:0] RdPC;
  logic [31:0] RdInst;
  logic [31:0] RdAlu;

  modport master (
    output RdValid,
    output RdPC,
    output RdInst,
    output RdAlu,
    input  RdReady
  );

  modport slave (
    input  RdValid,
    input  RdPC,
    input  RdInst,
    input  RdAlu,
    output RdReady
  );
endinterface

// File: rtl/ppcpu_trace_buffer_ram.sv
// Trace storage: DEPTH x TRC_W, one synchronous write port and one
// asynchronous (combinational) read port. Storage is not reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : entry to write
//   raddr_i : read address
//   rdata_o : entry at raddr_i
module ppcpu_trace_ram
  import ppcpu_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  trc_entry_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output trc_entry_t    rdata_o
);

  trc_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ppcpu_trace_buffer.sv
// Trace buffer observing the pipelined CPU debug outputs.
// Once armed, one entry {PC, ID_Inst, WB_Alu} is recorded per clock into a
// circular buffer. A PC match against TrigPC freezes a window of up to DEPTH
// entries (pre-trigger history, the trigger entry, POST entries after it),
// which is then streamed out oldest-first over the valid/ready read port.
//   Clock   : clock, all state on rising edge
//   Resetn  : asynchronous active-low reset
//   Arm     : 1-cycle start/restart request
//   TrigPC  : PC value that fires the trigger
//   PC, ID_Inst, WB_Alu : observed CPU signals
//   rd      : read port (RdValid/RdReady/RdPC/RdInst/RdAlu)
//   State   : 0=IDLE 1=ARMED 2=POST 3=DUMP
//   Count   : entries currently held (0..DEPTH)
module ppcpu_trace_buffer
  import ppcpu_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned POST  = 8
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 Arm,
  input  logic [31:0]          TrigPC,
  input  logic [31:0]          PC,
  input  logic [31:0]          ID_Inst,
  input  logic [31:0]          WB_Alu,
  ppcpu_trace_buffer_if.master rd,
  output logic [1:0]           State,
  output logic [AW:0]          Count
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_LD  = AW'(POST);

  trc_state_e    state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] post_q, post_d;

  logic          we;
  logic [AW-1:0] wptr_inc;
  logic [AW:0]   count_sat_inc;
  logic          rd_valid;
  trc_entry_t    wr_entry;
  trc_entry_t    rd_entry;

  assign wr_entry      = trc_pack(PC, ID_Inst, WB_Alu);
  assign wptr_inc      = wptr_q + 1'b1;
  assign count_sat_inc = (count_q == CNT_FULL) ? count_q : count_q + 1'b1;
  assign rd_valid      = (state_q == TRC_DUMP) && (count_q != '0);

  ppcpu_trace_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (Clock),
    .we_i    (we),
    .waddr_i (wptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rptr_q),
    .rdata_o (rd_entry)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= TRC_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      post_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      post_q  <= post_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    post_d  = post_q;
    we      = 1'b0;

    unique case (state_q)
      TRC_IDLE: begin
        if (Arm) begin
          state_d = TRC_ARMED;
          wptr_d  = '0;
          count_d = '0;
        end
      end

      TRC_ARMED: begin
        if (Arm) begin
          // Restart takes priority over both the write and a trigger match.
          wptr_d  = '0;
          count_d = '0;
        end else begin
          we      = 1'b1;
          wptr_d  = wptr_inc;
          count_d = count_sat_inc;
          if (PC == TrigPC) begin
            post_d  = POST_LD;
            state_d = TRC_POST;
          end
        end
      end

      TRC_POST: begin
        we      = 1'b1;
        wptr_d  = wptr_inc;
        count_d = count_sat_inc;
        post_d  = post_q - 1'b1;
        if (post_q == AW'(1)) begin
          // Oldest entry of the window sits Count slots behind the post-write
          // pointer; a full buffer truncates to rptr == wptr.
          state_d = TRC_DUMP;
          rptr_d  = wptr_inc - count_sat_inc[AW-1:0];
        end
      end

      TRC_DUMP: begin
        if (rd_valid && rd.RdReady) begin
          rptr_d  = rptr_q + 1'b1;
          count_d = count_q - 1'b1;
          if (count_q == (AW+1)'(1)) begin
            state_d = TRC_IDLE;
          end
        end
      end

      default: state_d = TRC_IDLE;
    endcase
  end

  assign rd.RdValid = rd_valid;
  assign rd.RdPC    = rd_valid ? rd_entry.pc   : '0;
  assign rd.RdInst  = rd_valid ? rd_entry.inst : '0;
  assign rd.RdAlu   = rd_valid ? rd_entry.alu  : '0;

  assign State = state_q;
  assign Count = count_q;

endmodule

// File: tb/tb_ppcpu_trace_buffer.sv
module tb_ppcpu_trace_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int POST  = 8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu;
  } ent_t;

  logic        Clock;
  logic        Resetn;
  logic        Arm;
  logic [31:0] TrigPC;
  logic [31:0] PC;
  logic [31:0] ID_Inst;
  logic [31:0] WB_Alu;
  logic [1:0]  State;
  logic [AW:0] Count;

  ppcpu_trace_buffer_if rd_if ();

  ppcpu_trace_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .POST  (POST)
  ) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Arm     (Arm),
    .TrigPC  (TrigPC),
    .PC      (PC),
    .ID_Inst (ID_Inst),
    .WB_Alu  (WB_Alu),
    .rd      (rd_if.master),
    .State   (State),
    .Count   (Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int   checks = 0;
  int   errors = 0;
  ent_t hist[$];
  ent_t expq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_state"}, 32'(State), 32'd0);
    chk({tag, "_count"}, 32'(Count), 32'd0);
    chk({tag, "_valid"}, 32'(rd_if.RdValid), 32'd0);
    chk({tag, "_pc"},    rd_if.RdPC, 32'd0);
    chk({tag, "_inst"},  rd_if.RdInst, 32'd0);
    chk({tag, "_alu"},   rd_if.RdAlu, 32'd0);
  endtask

  // Capture one window. Called at a negedge with the buffer idle.
  // pre: non-matching entries before the trigger; seq: PC = 4*i stream;
  // restart_at > 0: write that many entries, then re-arm from ARMED.
  task automatic capture(input logic [31:0] trig, input int pre, input bit seq,
                         input int restart_at);
    int n;
    int k;
    logic [31:0] pc;
    ent_t e;
    hist.delete();
    expq.delete();
    TrigPC = trig;
    Arm = 1'b1;
    PC = $urandom;
    @(negedge Clock);
    Arm = 1'b0;
    chk("arm_state", 32'(State), 32'd1);
    chk("arm_count", 32'(Count), 32'd0);

    if (restart_at > 0) begin
      for (int j = 0; j < restart_at; j++) begin
        pc = $urandom;
        if (pc == trig) pc = pc ^ 32'h4;
        e.pc = pc; e.inst = $urandom; e.alu = $urandom;
        PC = e.pc; ID_Inst = e.inst; WB_Alu = e.alu;
        @(negedge Clock);
        chk("pre_restart_count", 32'(Count), 32'(j + 1));
      end
      Arm = 1'b1;
      PC = trig;
      @(negedge Clock);
      Arm = 1'b0;
      chk("restart_count", 32'(Count), 32'd0);
      chk("restart_state", 32'(State), 32'd1);
    end

    n = pre + 1 + POST;
    for (int i = 0; i < n; i++) begin
      if (seq) begin
        pc = 32'(i * 4);
      end else if (i == pre) begin
        pc = trig;
      end else if (i < pre) begin
        pc = $urandom;
        if (pc == trig) pc = pc ^ 32'h4;
      end else begin
        // After the trigger, repeated matches and Arm must both be ignored.
        pc = ($urandom_range(0, 3) == 0) ? trig : $urandom;
        Arm = 1'($urandom_range(0, 1));
      end
      e.pc = pc; e.inst = $urandom; e.alu = $urandom;
      PC = e.pc; ID_Inst = e.inst; WB_Alu = e.alu;
      hist.push_back(e);
      @(negedge Clock);
      Arm = 1'b0;
      chk("cap_count", 32'(Count), 32'(imin(DEPTH, i + 1)));
      chk("cap_state", 32'(State), (i < pre) ? 32'd1 : (i < pre + POST) ? 32'd2 : 32'd3);
    end

    k = imin(DEPTH, hist.size());
    for (int j = hist.size() - k; j < hist.size(); j++) expq.push_back(hist[j]);
  endtask

  // Drain the frozen window. mode 0: always ready; 1: ready pattern 1,0,0;
  // 2: random ready with Arm pulsed during DUMP.
  task automatic drain(input int mode);
    int cyc;
    bit rdy;
    bit timed_out;
    cyc = 0;
    timed_out = 1'b0;
    forever begin
      chk("drain_count", 32'(Count), 32'(expq.size()));
      if (expq.size() == 0) begin
        check_idle_outputs("drain_done");
        break;
      end
      chk("rd_valid", 32'(rd_if.RdValid), 32'd1);
      chk("rd_pc",    rd_if.RdPC,   expq[0].pc);
      chk("rd_inst",  rd_if.RdInst, expq[0].inst);
      chk("rd_alu",   rd_if.RdAlu,  expq[0].alu);
      if (cyc >= 300) begin
        timed_out = 1'b1;
        chk("drain_budget", 32'(timed_out), 32'd0);
        break;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3) == 0;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      Arm = (mode == 2) && (cyc < 2);
      PC = TrigPC;
      rd_if.RdReady = rdy;
      if (rdy) void'(expq.pop_front());
      @(negedge Clock);
      cyc++;
    end
    rd_if.RdReady = 1'b0;
    Arm = 1'b0;
  endtask

  initial begin
    Resetn = 1'b0;
    Arm = 1'b0;
    TrigPC = '0;
    PC = '0;
    ID_Inst = '0;
    WB_Alu = '0;
    rd_if.RdReady = 1'b0;

    // Reset held for 100 ns; outputs observed while in reset.
    #50;
    check_idle_outputs("reset");
    #50;
    Resetn = 1'b1;
    @(negedge Clock);
    check_idle_outputs("post_reset");

    // Sequential PCs, trigger at 0x20: 17 writes, window PC 0x04..0x40.
    capture(32'h20, 8, 1'b1, 0);
    chk("seq_first_pc", expq[0].pc, 32'h04);
    drain(0);

    // Early trigger at the very first entry: 9-entry window PC 0x00..0x20.
    capture(32'h0, 0, 1'b1, 0);
    chk("early_size", 32'(expq.size()), 32'd9);
    drain(0);

    // Backpressure pattern 1,0,0.
    capture($urandom, 5, 1'b0, 0);
    drain(1);

    // Arm in DUMP ignored; long pre-history wrapping the buffer.
    capture($urandom, 30, 1'b0, 0);
    drain(2);

    // Restart from ARMED after 5 writes.
    capture($urandom, 3, 1'b0, 5);
    drain(2);

    // A few more random windows.
    for (int t = 0; t < 4; t++) begin
      capture($urandom, $urandom_range(0, 20), 1'b0, 0);
      drain(2);
    end

    // Asynchronous reset mid-POST.
    TrigPC = 32'h1234;
    Arm = 1'b1;
    @(negedge Clock);
    Arm = 1'b0;
    PC = 32'h1234;
    @(negedge Clock);
    PC = 32'h5678;
    @(negedge Clock);
    @(negedge Clock);
    chk("midpost_state", 32'(State), 32'd2);
    #2;
    Resetn = 1'b0;
    #1;
    chk("async_state", 32'(State), 32'd0);
    chk("async_count", 32'(Count), 32'd0);
    chk("async_valid", 32'(rd_if.RdValid), 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    check_idle_outputs("after_async");

    // Normal operation after the abort.
    capture(32'h20, 8, 1'b1, 0);
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
